// File: rtl/int_mac_accum.sv
// Accumulates vec_len signed products onto a seed; result is presented 1 cycle after the last p_valid and held until res_ready.
// Optional INT_MAC_ACCUM_SAT_EN saturates the accumulator on signed overflow instead of wrapping.
module int_mac_accum #(
    parameter int P_DATA_WIDTH   = 44,
    parameter int ACC_DATA_WIDTH = 48,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_WIDTH-1:0]      vec_len,
    input  logic [P_DATA_WIDTH-1:0]   acc_init,
    input  logic                      p_valid,
    input  logic [P_DATA_WIDTH-1:0]   p,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ACC_DATA_WIDTH-1:0] res,
    output logic                      busy,
    output logic                      ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_e;

    state_e                    state_q;
    logic [ACC_DATA_WIDTH-1:0] acc_q;
    logic [ACC_DATA_WIDTH-1:0] acc_d;
    logic [LEN_WIDTH-1:0]      cnt_q;
    logic                      ovf_q;

    logic [ACC_DATA_WIDTH-1:0] init_ext;
    logic [ACC_DATA_WIDTH-1:0] p_ext;
    logic [ACC_DATA_WIDTH-1:0] sum;
    logic                      add_ovf;

    assign init_ext = ACC_DATA_WIDTH'($signed(acc_init));
    assign p_ext    = ACC_DATA_WIDTH'($signed(p));
    assign sum      = acc_q + p_ext;

    // Overflow only when both operands share a sign that the sum does not.
    assign add_ovf = (acc_q[ACC_DATA_WIDTH-1] == p_ext[ACC_DATA_WIDTH-1]) &&
                     (sum[ACC_DATA_WIDTH-1] != acc_q[ACC_DATA_WIDTH-1]);

`ifdef INT_MAC_ACCUM_SAT_EN
    localparam logic [ACC_DATA_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_DATA_WIDTH-1){1'b1}}};
    localparam logic [ACC_DATA_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_DATA_WIDTH-1){1'b0}}};

    always_comb begin
        acc_d = sum;
        if (add_ovf) begin
            acc_d = acc_q[ACC_DATA_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    always_comb begin
        acc_d = sum;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A product arriving alongside start is not part of the vector.
                    if (start) begin
                        acc_q   <= init_ext;
                        cnt_q   <= vec_len;
                        ovf_q   <= 1'b0;
                        state_q <= (vec_len == '0) ? S_HOLD : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (p_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - LEN_WIDTH'(1);
                        ovf_q <= ovf_q | add_ovf;
                        if (cnt_q == LEN_WIDTH'(1)) begin
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign res_valid = (state_q == S_HOLD);
    assign res       = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/int_mac_accum.md
INT_MAC_ACCUM -- requirements
Module: int_mac_accum

Interface
REQ-001 Parameter P_DATA_WIDTH, default 44, width of the signed product input and the init value.
REQ-002 Parameter ACC_DATA_WIDTH, default 48, width of the signed accumulator and result; SHALL be >= P_DATA_WIDTH.
REQ-003 Parameter LEN_WIDTH, default 8, width of the vector-length field.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 start  input  1  one-cycle pulse; begins a vector accumulation; sampled only in IDLE.
REQ-007 vec_len  input  LEN_WIDTH  number of products to accumulate; unsigned; sampled with start.
REQ-008 acc_init  input  P_DATA_WIDTH  signed seed value; sign-extended and loaded with start.
REQ-009 p_valid  input  1  qualifies p; one product per cycle when high.
REQ-010 p  input  P_DATA_WIDTH  signed product from the upstream registered multiply-add stage.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  downstream accepts result when high with res_valid.
REQ-013 res  output  ACC_DATA_WIDTH  signed accumulated result.
REQ-014 busy  output  1  high in ACCUM or HOLD.
REQ-015 ovf  output  1  signed overflow occurred during the current vector; valid alongside res.

Function
REQ-016 FSM states IDLE, ACCUM, HOLD; encoding free.
REQ-017 IDLE: start=1 and vec_len>0 -> acc <= sext(acc_init), cnt <= vec_len, ovf <= 0, go ACCUM.
REQ-018 IDLE: start=1 and vec_len=0 -> acc <= sext(acc_init), ovf <= 0, go HOLD directly (res_valid next cycle).
REQ-019 ACCUM: each cycle with p_valid=1 -> acc <= acc + sext(p), cnt <= cnt-1; p_valid=0 -> hold acc and cnt.
REQ-020 ACCUM: the update consuming the last product (cnt=1, p_valid=1) -> go HOLD; res_valid high the following cycle (latency 1 cycle after last p_valid).
REQ-021 HOLD: res_valid=1, res=acc stable; res_valid & res_ready -> go IDLE the next cycle; res_valid drops same edge.
REQ-022 start while busy SHALL be ignored; no state or counter change.
REQ-023 p_valid in IDLE or HOLD SHALL be ignored; acc unchanged.
REQ-024 start and p_valid in same IDLE cycle: start taken, product ignored (first product counted from next cycle).
REQ-025 Overflow: sign of both operands equal and sum sign differs -> ovf set, sticky until next accepted start.
REQ-026 Without saturation (REQ-033), overflowed sum wraps modulo 2^ACC_DATA_WIDTH.
REQ-027 busy = (state != IDLE); res_valid = (state == HOLD), both registered-state decodes.
REQ-028 res SHALL hold its last value in IDLE (not cleared on handshake).

Reset
REQ-029 reset=1 on a clock edge -> state IDLE, acc=0, cnt=0, ovf=0.
REQ-030 Outputs after reset: res_valid=0, busy=0, res=0, ovf=0.
REQ-031 reset mid-ACCUM or mid-HOLD SHALL abort the vector; no result is presented; reset priority over all inputs.
REQ-032 First start accepted on the first edge with reset=0.

Configuration
REQ-033 Macro INT_MAC_ACCUM_SAT_EN defined: on overflow acc saturates to max positive (2^(ACC_DATA_WIDTH-1)-1) or min negative (-2^(ACC_DATA_WIDTH-1)) per operand sign; ovf still set; further adds proceed from the saturated value.
REQ-034 Macro undefined: wrap-around per REQ-026; no saturation logic present.

Verification
REQ-035 Reset then start, vec_len=4, acc_init=10, p=1,2,3,4 back-to-back -> res=20, res_valid one cycle after 4th p_valid, ovf=0.
REQ-036 vec_len=3, acc_init=0, p=-5,(gap 2 cycles),7,-100 with res_ready held low 5 cycles -> res=-98 held stable until ready, then res_valid=0, busy=0.
REQ-037 start with vec_len=0, acc_init=-1 -> res_valid next cycle, res=-1 sign-extended (all ones), ovf=0.
REQ-038 ACC_DATA_WIDTH=44, acc_init=2^43-1, vec_len=1, p=1 -> without macro res=-2^43, ovf=1; with INT_MAC_ACCUM_SAT_EN res=2^43-1, ovf=1.
REQ-039 start pulse during ACCUM and p_valid during HOLD -> ignored; result equals undisturbed reference sum.
REQ-040 reset asserted after 2 of 4 products -> busy=0, res_valid=0, res=0 next cycle; new start with vec_len=1, p=9, acc_init=0 -> res=9.
